// File: rtl/pio_update_arbiter.sv
// Round-robin sequencer in front of a 32-bit output PIO. Each granted update
// is one write followed by a readback verify, with bounded retry, and then an
// ack pulse plus an optional hold-off gap before the next grant.
module pio_update_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MIN_GAP   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   ack_err,
  output logic [1:0]             avm_address,
  output logic                   avm_chipselect,
  output logic                   avm_write_n,
  output logic [31:0]            avm_writedata,
  input  logic [31:0]            avm_readdata,
  output logic                   busy,
  output logic                   err_sticky,
  input  logic                   err_clear,
  output logic [15:0]            update_count
);

  localparam int                IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                SUM_W      = IDX_W + 1;
  localparam logic [SUM_W-1:0]  NUM_SUM    = SUM_W'(NUM_REQ);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REQ - 1);
  localparam logic [2:0]        RETRY_LAST = 3'(MAX_RETRY);
  localparam logic [7:0]        GAP_LAST   = 8'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_ACK,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [SUM_W-1:0]   w_sum;
  logic               w_req_any;
  logic [31:0]        r_data;
  logic [31:0]        w_sel_data;
  logic               w_match;
  logic [2:0]         r_retry_cnt;
  logic [7:0]         r_gap_cnt;
  logic [NUM_REQ-1:0] w_ack_onehot;

  logic [NUM_REQ-1:0] r_ack;
  logic               r_ack_err;
  logic               r_chipselect;
  logic               r_write_n;
  logic [31:0]        r_writedata;
  logic               r_busy;
  logic               r_err_sticky;
  logic [15:0]        r_update_count;

  assign w_match      = (avm_readdata == r_data);
  assign w_ack_onehot = NUM_REQ'(1) << r_grant;

  // Round-robin search: the lowest offset from r_rr_ptr with req set wins.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_req_any   = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
      if (w_sum >= NUM_SUM) w_sum = w_sum - NUM_SUM;
      if (req[w_sum[IDX_W-1:0]]) begin
        w_req_any   = 1'b1;
        w_grant_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  // Select the granted requester's data word.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == IDX_W'(k)) w_sel_data = req_data[32*k +: 32];
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_next_state = S_WRITE;
      S_WRITE:  w_next_state = S_VERIFY;
      S_VERIFY: w_next_state = (w_match || (r_retry_cnt == RETRY_LAST)) ? S_ACK : S_WRITE;
      S_ACK:    w_next_state = (MIN_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register plus grant, data, retry, gap and round-robin bookkeeping.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_data      <= '0;
      r_retry_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant     <= w_grant_idx;
            r_data      <= w_sel_data;
            r_retry_cnt <= '0;
          end
        end
        S_VERIFY: begin
          if (!w_match && (r_retry_cnt != RETRY_LAST)) r_retry_cnt <= r_retry_cnt + 3'd1;
        end
        S_ACK: begin
          r_rr_ptr  <= (r_grant == IDX_LAST) ? '0 : r_grant + IDX_W'(1);
          r_gap_cnt <= '0;
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Registered bus and handshake outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack        <= '0;
      r_ack_err    <= 1'b0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_ack        <= (w_next_state == S_ACK) ? w_ack_onehot : '0;
      // ACK is only entered from VERIFY, so a mismatch here means retries ran out.
      r_ack_err    <= (w_next_state == S_ACK) && !w_match;
      r_chipselect <= (w_next_state == S_WRITE) || (w_next_state == S_VERIFY);
      r_write_n    <= (w_next_state != S_WRITE);
      r_busy       <= (w_next_state != S_IDLE);
      if (w_next_state == S_WRITE) r_writedata <= (r_state == S_IDLE) ? w_sel_data : r_data;
    end
  end

  // Error flag (set beats clear) and success counter, updated as ACK completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_sticky   <= 1'b0;
      r_update_count <= '0;
    end else begin
      if ((r_state == S_ACK) && r_ack_err) r_err_sticky <= 1'b1;
      else if (err_clear)                  r_err_sticky <= 1'b0;
      if ((r_state == S_ACK) && !r_ack_err) r_update_count <= r_update_count + 16'd1;
    end
  end

  assign ack            = r_ack;
  assign ack_err        = r_ack_err;
  assign avm_address    = 2'b00;
  assign avm_chipselect = r_chipselect;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = r_writedata;
  assign busy           = r_busy;
  assign err_sticky     = r_err_sticky;
  assign update_count   = r_update_count;

endmodule

// File: tb/tb_pio_update_arbiter.sv
// Bench for pio_update_arbiter: a PIO slave model, a transaction-schedule
// reference model compared every cycle, and directed scenarios with literal
// expectations for latency, write sequences and error handling.
module tb_pio_update_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int MIN_GAP   = 4;
  localparam int MAX_RETRY = 2;
  localparam int IDX_W     = 2;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_err;
  logic [1:0]            avm_address;
  logic                  avm_chipselect;
  logic                  avm_write_n;
  logic [31:0]           avm_writedata;
  logic [31:0]           avm_readdata;
  logic                  busy;
  logic                  err_sticky;
  logic                  err_clear;
  logic [15:0]           update_count;

  logic [31:0] data_arr [NUM_REQ];

  pio_update_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MIN_GAP  (MIN_GAP),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .ack_err       (ack_err),
    .avm_address   (avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n   (avm_write_n),
    .avm_writedata (avm_writedata),
    .avm_readdata  (avm_readdata),
    .busy          (busy),
    .err_sticky    (err_sticky),
    .err_clear     (err_clear),
    .update_count  (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = data_arr[k];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", name, got, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ack within cycle budget @%0t", name, $time);
  endtask

  // ---------------- PIO slave model ----------------
  // Register is not reset with the arbiter; it keeps whatever was last written.
  logic [31:0] pio_reg  = '0;
  logic [31:0] writes[$];
  logic        stuck    = 1'b0;
  int          arm_seq  = 0;
  int          used_seq = 0;

  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n) begin
      pio_reg <= avm_writedata;
      writes.push_back(avm_writedata);
    end
    if (avm_chipselect && avm_write_n) used_seq <= arm_seq;
  end

  // One armed corruption flips bit 0 on the next readback; stuck forces all ones.
  assign avm_readdata = stuck ? 32'hFFFF_FFFF :
                        (arm_seq != used_seq) ? (pio_reg ^ 32'h1) : pio_reg;

  // ---------------- reference model ----------------
  // m_t counts cycles since grant: 1..2n alternate write/verify, 2n+1 is the
  // ack cycle, then MIN_GAP gap cycles, then 0 (idle).
  int               m_t = 0;
  int               m_n = 1;
  int               m_rr = 0;
  int               cand;
  int               bad;
  logic [IDX_W-1:0] m_grant = '0;
  logic             m_err = 1'b0;
  logic [31:0]      m_data = '0;
  logic [31:0]      e_wdata = '0;
  logic [15:0]      e_count = '0;
  logic             e_sticky = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_n = 1; m_rr = 0; m_grant = '0; m_err = 1'b0;
      e_wdata = '0; e_count = '0; e_sticky = 1'b0;
    end else begin
      if (m_t == 2*m_n + 1) begin
        m_rr = (int'(m_grant) + 1) % NUM_REQ;
        if (!m_err) e_count = e_count + 16'd1;
        if (m_err) e_sticky = 1'b1;
        else if (err_clear) e_sticky = 1'b0;
      end else if (err_clear) begin
        e_sticky = 1'b0;
      end
      if (m_t == 0) begin
        if (req != '0) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            cand = (m_rr + k) % NUM_REQ;
            if (req[IDX_W'(cand)]) begin
              m_grant = IDX_W'(cand);
              break;
            end
          end
          m_data = data_arr[m_grant];
          bad    = stuck ? 100 : ((arm_seq != used_seq) ? 1 : 0);
          m_n    = ((bad > MAX_RETRY) ? MAX_RETRY : bad) + 1;
          m_err  = (bad > MAX_RETRY);
          m_t    = 1;
        end
      end else begin
        m_t = m_t + 1;
        if (m_t > 2*m_n + 1 + MIN_GAP) m_t = 0;
      end
      if ((m_t >= 1) && (m_t <= 2*m_n) && (m_t % 2 == 1)) e_wdata = m_data;
    end
  end

  logic             e_cs, e_wn, e_busy, e_ack_err;
  logic [NUM_REQ-1:0] e_ack;

  always_comb begin
    e_cs      = (m_t >= 1) && (m_t <= 2*m_n);
    e_wn      = !(e_cs && (m_t % 2 == 1));
    e_busy    = (m_t != 0);
    e_ack     = (m_t == 2*m_n + 1) ? (3'b001 << m_grant) : 3'b000;
    e_ack_err = (m_t == 2*m_n + 1) && m_err;
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ack",        32'(ack),            32'(e_ack));
      check("cyc_ack_err",    32'(ack_err),        32'(e_ack_err));
      check("cyc_chipselect", 32'(avm_chipselect), 32'(e_cs));
      check("cyc_write_n",    32'(avm_write_n),    32'(e_wn));
      check("cyc_writedata",  avm_writedata,       e_wdata);
      check("cyc_address",    32'(avm_address),    32'd0);
      check("cyc_busy",       32'(busy),           32'(e_busy));
      check("cyc_err_sticky", 32'(err_sticky),     32'(e_sticky));
      check("cyc_count",      32'(update_count),   32'(e_count));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int idx, input int budget, input string name, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (((ack >> idx) & 3'b001) != 3'b000) return;
    end
    timeout_fail(name);
  endtask

  int lat;
  int wbase;
  int n_got;
  int got_idx [4];
  int got_cyc [4];
  logic [31:0] exp_seq [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = '0; err_clear = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) data_arr[k] = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_ack",        32'(ack),            32'd0);
    check("rst_chipselect", 32'(avm_chipselect), 32'd0);
    check("rst_write_n",    32'(avm_write_n),    32'd1);
    check("rst_writedata",  avm_writedata,       32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_count",      32'(update_count),   32'd0);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // 1: single request
    wbase = writes.size();
    data_arr[0] = 32'h0000_1234;
    req = 3'b001;
    wait_ack(0, 20, "t1_ack", lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_ack_err", 32'(ack_err), 32'd0);
    req = 3'b000;
    tick(MIN_GAP + 3);
    check("t1_nwrites", 32'(writes.size() - wbase), 32'd1);
    if (writes.size() > wbase) check("t1_wdata", writes[wbase], 32'h0000_1234);
    check("t1_count", 32'(update_count), 32'd1);

    // 2: round-robin from a fresh reset
    reset = 1'b1; tick(2); reset = 1'b0;
    wbase = writes.size();
    data_arr[0] = 32'hAAAA_0001;
    data_arr[1] = 32'hBBBB_0002;
    data_arr[2] = 32'hCCCC_0003;
    exp_seq[0] = 32'hAAAA_0001; exp_seq[1] = 32'hBBBB_0002;
    exp_seq[2] = 32'hCCCC_0003; exp_seq[3] = 32'hAAAA_0001;
    for (int i = 0; i < 4; i++) begin got_idx[i] = -1; got_cyc[i] = 0; end
    n_got = 0;
    req = 3'b111;
    for (int e = 0; (e < 200) && (n_got < 4); e++) begin
      @(posedge clk); #1;
      if (ack != 3'b000) begin
        got_idx[n_got] = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 7;
        got_cyc[n_got] = cyc;
        n_got++;
      end
    end
    req = 3'b000;
    check("t2_nacks", 32'(n_got), 32'd4);
    check("t2_grant0", 32'(got_idx[0]), 32'd0);
    check("t2_grant1", 32'(got_idx[1]), 32'd1);
    check("t2_grant2", 32'(got_idx[2]), 32'd2);
    check("t2_grant3", 32'(got_idx[3]), 32'd0);
    for (int i = 1; i < 4; i++) check("t2_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd8);
    tick(MIN_GAP + 3);
    check("t2_nwrites", 32'(writes.size() - wbase), 32'd4);
    for (int i = 0; i < 4; i++)
      if (writes.size() > wbase + i) check("t2_wseq", writes[wbase + i], exp_seq[i]);
    check("t2_count", 32'(update_count), 32'd4);

    // 3: first readback corrupted, second attempt succeeds
    wbase = writes.size();
    data_arr[1] = 32'h1357_9BDF;
    arm_seq = arm_seq + 1;
    req = 3'b010;
    wait_ack(1, 30, "t3_ack", lat);
    check("t3_latency", 32'(lat), 32'd5);
    check("t3_ack_err", 32'(ack_err), 32'd0);
    req = 3'b000;
    tick(MIN_GAP + 3);
    check("t3_nwrites", 32'(writes.size() - wbase), 32'd2);
    check("t3_count", 32'(update_count), 32'd5);

    // 4: readback stuck high, retries exhausted
    wbase = writes.size();
    data_arr[2] = 32'h0000_0005;
    stuck = 1'b1;
    req = 3'b100;
    wait_ack(2, 30, "t4_ack", lat);
    check("t4_latency", 32'(lat), 32'd7);
    check("t4_ack_err", 32'(ack_err), 32'd1);
    req = 3'b000;
    tick(MIN_GAP + 3);
    check("t4_nwrites", 32'(writes.size() - wbase), 32'd3);
    for (int i = 0; i < 3; i++)
      if (writes.size() > wbase + i) check("t4_wdata", writes[wbase + i], 32'h0000_0005);
    check("t4_sticky", 32'(err_sticky), 32'd1);
    check("t4_count", 32'(update_count), 32'd5);

    // 5: err_clear coincides with an error ack; set wins, later clear works
    data_arr[0] = 32'h0000_0077;
    req = 3'b001;
    wait_ack(0, 30, "t5_ack", lat);
    check("t5_ack_err", 32'(ack_err), 32'd1);
    req = 3'b000;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("t5_sticky_kept", 32'(err_sticky), 32'd1);
    stuck = 1'b0;
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("t5_sticky_cleared", 32'(err_sticky), 32'd0);
    tick(MIN_GAP + 3);

    // 6: reset during VERIFY, then normal grant from rr_ptr = 0
    data_arr[1] = 32'h2468_ACE0;
    req = 3'b010;
    @(posedge clk); @(posedge clk); #2;
    check("t6_in_verify_cs", 32'(avm_chipselect), 32'd1);
    check("t6_in_verify_wn", 32'(avm_write_n), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_cs",   32'(avm_chipselect), 32'd0);
    check("t6_rst_wn",   32'(avm_write_n),    32'd1);
    check("t6_rst_busy", 32'(busy),           32'd0);
    check("t6_rst_ack",  32'(ack),            32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    data_arr[0] = 32'h0000_00A5;
    data_arr[1] = 32'h0000_00B6;
    req = 3'b011;
    wait_ack(0, 20, "t6_ack0", lat);
    check("t6_latency", 32'(lat), 32'd3);
    req = 3'b010;
    wait_ack(1, 30, "t6_ack1", lat);
    check("t6_spacing", 32'(lat), 32'd8);
    req = 3'b000;
    tick(MIN_GAP + 3);
    check("t6_pio", pio_reg, 32'h0000_00B6);
    check("t6_count", 32'(update_count), 32'd2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pio_update_arbiter.md
Name: pio_update_arbiter

Overview:
- Sequencer and arbiter in front of the 32-bit output PIO Avalon-MM slave (single data register at address 0, combinational readdata).
- Shares the PIO between NUM_REQ internal requesters (e.g. tilt-X, tilt-Y, status word) using round-robin grants.
- Each update is a single write followed by a readback verify, with bounded retry.
- A programmable hold-off gap between updates guarantees downstream logic sees every value stable for a minimum time.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MIN_GAP, 4, idle cycles enforced after each ack before the next grant (0..255; 0 = no gap state).
- MAX_RETRY, 2, additional write attempts after a readback mismatch (0..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester update request; level, held until ack.
- req_data  in  NUM_REQ*32  requester i value in bits [32*i+31:32*i].
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- ack_err  out  1  qualifies ack; 1 = retries exhausted, value not confirmed.
- avm_address  out  2  PIO address; always 0.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO write strobe, active low.
- avm_writedata  out  32  PIO write data.
- avm_readdata  in  32  PIO readdata (combinational from the slave).
- busy  out  1  high in any state other than IDLE.
- err_sticky  out  1  set by any ack_err; cleared by err_clear.
- err_clear  in  1  clears err_sticky.
- update_count  out  16  count of successful (ack_err=0) updates; wraps.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, ack_err=0, avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, busy=0, err_sticky=0, update_count=0, state=IDLE, rr_ptr=0, retry_cnt=0.
- FSM states: IDLE, WRITE, VERIFY, ACK, GAP.
- IDLE:
  - If any req is set, grant the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Latch grant index and its req_data into data_q; set retry_cnt=0; go to WRITE.
  - With no req set, remain in IDLE.
- WRITE (1 cycle): avm_chipselect=1, avm_write_n=0, avm_writedata=data_q; go to VERIFY.
- VERIFY (1 cycle):
  - avm_chipselect=1, avm_write_n=1; sample avm_readdata at the end of the cycle.
  - Match: go to ACK with ack_err=0.
  - Mismatch with retry_cnt<MAX_RETRY: increment retry_cnt and go to WRITE.
  - Mismatch with retry_cnt=MAX_RETRY: go to ACK with ack_err=1.
- ACK (1 cycle):
  - ack[grant]=1, ack_err valid; rr_ptr=(grant+1) mod NUM_REQ.
  - update_count increments if ack_err=0.
  - Go to GAP, or to IDLE if MIN_GAP=0.
- GAP: chipselect=0; count MIN_GAP cycles, then go to IDLE.
- Latency, req rising in IDLE to ack, with no mismatch: 3 cycles (grant at edge 1, WRITE, VERIFY, ACK).
  - Each retry adds 2 cycles.
  - Minimum spacing between consecutive acks: 4+MIN_GAP cycles.
- Request rules:
  - req and req_data are sampled only in IDLE; later changes to req_data do not affect the transaction in flight.
  - If req drops before ack, the transaction still completes and ack still pulses.
  - A requester that keeps req high after its ack is re-arbitrated normally; round-robin prevents starvation.
- err_sticky: set has priority over err_clear when both occur in the same cycle.
- update_count wraps from 0xFFFF to 0x0000.
- Outside WRITE and VERIFY, avm_chipselect=0 and avm_write_n=1; avm_writedata holds its last value.
- Reset asserted mid-transaction: immediate return to reset values. No ack is issued, and the PIO contents are whatever was last written.

Test Plan:
1. Single request: req=3'b001, req_data[31:0]=0x0000_1234. Required: one write of 0x1234 at address 0, ack[0] pulses 3 cycles after grant, ack_err=0, update_count=1.
2. Round-robin: all three req high continuously with data A/B/C. Required: grant order 0,1,2,0,…; acks spaced 4+MIN_GAP=8 cycles apart; PIO sequence A,B,C,A.
3. Mismatch recovery: bench PIO model corrupts readdata on the first VERIFY only. Required: exactly 2 writes, ack at cycle 5, ack_err=0.
4. Retries exhausted: readdata stuck at 0xFFFF_FFFF, data=0x5. Required: 3 writes (MAX_RETRY+1), ack with ack_err=1, err_sticky=1, update_count unchanged.
5. Simultaneous events: err_clear asserted in the same cycle as an ack_err=1 ack. Required: err_sticky remains 1; a later err_clear with no error clears it to 0.
6. Reset mid-operation: assert reset during VERIFY. Required: same cycle returns chipselect=0, write_n=1, busy=0, no ack; after release, rr_ptr=0 and a new request is granted normally.
